// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - packet transmitter: buffers payload bytes, sends header, payload and parity to a router port
module router_pkt_tx #(
  parameter int MAX_LEN = 63
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_active,
  output logic       load_full,
  output logic       done,
  output logic       err
);

  localparam logic [5:0] MAX_CNT = 6'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_t;

  state_t     state;
  logic [5:0] count;
  logic [5:0] idx;
  logic [7:0] par;
  logic [7:0] mem [MAX_LEN];
  logic       accept;
  logic       do_write;

  assign accept    = tx_active && !busy;
  assign do_write  = (state == IDLE) && wr_en && !start && (count < MAX_CNT);
  assign load_full = (count == MAX_CNT);

  // Payload storage is not reset; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_write) mem[count] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state     <= IDLE;
      count     <= 6'd0;
      idx       <= 6'd0;
      par       <= 8'h00;
      data_out  <= 8'h00;
      pkt_valid <= 1'b0;
      tx_active <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count == 6'd0 || dest_addr == 2'b11) begin
              err <= 1'b1;
            end else begin
              state     <= HEADER;
              data_out  <= {count, dest_addr};
              par       <= {count, dest_addr};
              pkt_valid <= 1'b1;
              tx_active <= 1'b1;
            end
          end else if (do_write) begin
            count <= count + 6'd1;
          end
        end
        HEADER: begin
          if (accept) begin
            state    <= PAYLOAD;
            data_out <= mem[0];
            idx      <= 6'd1;
          end
        end
        PAYLOAD: begin
          // idx counts bytes already presented; the one on data_out is mem[idx-1]
          if (accept) begin
            par <= par ^ data_out;
            if (idx == count) begin
              state     <= PARITY;
              data_out  <= par ^ data_out;
              pkt_valid <= 1'b0;
            end else begin
              data_out <= mem[idx];
              idx      <= idx + 6'd1;
            end
          end
        end
        PARITY: begin
          if (accept) begin
            state     <= IDLE;
            done      <= 1'b1;
            count     <= 6'd0;
            data_out  <= 8'h00;
            tx_active <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - self-checking bench for router_pkt_tx
module tb_router_pkt_tx;
  localparam int MAX_LEN = 63;

  logic       clk = 1'b0;
  logic       reset_in;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       start;
  logic [1:0] dest_addr;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_active;
  logic       load_full;
  logic       done;
  logic       err;

  router_pkt_tx #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset_in(reset_in), .wr_en(wr_en), .wr_data(wr_data),
    .start(start), .dest_addr(dest_addr), .busy(busy), .data_out(data_out),
    .pkt_valid(pkt_valid), .tx_active(tx_active), .load_full(load_full),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [23:0] bytes;
    logic [1:0]  addr;
    logic [7:0]  hdr;
    logic [7:0]  par;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] pl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
    if (pl.size() < MAX_LEN) pl.push_back(b);
    check("load_full", load_full, pl.size() == MAX_LEN);
  endtask

  // Reference: stream = header, payload bytes, parity(XOR of everything before it).
  task automatic xmit(input logic [1:0] addr, input int pct, input logic [31:0] mask,
                      input bit with_wr, output logic [7:0] got_hdr,
                      output logic [7:0] got_par, output int cycles);
    logic [7:0] exp[$];
    logic [7:0] p;
    int         k;
    int         n;
    p = 8'((pl.size() << 2) | int'(addr));
    exp.push_back(p);
    foreach (pl[i]) begin
      exp.push_back(pl[i]);
      p = p ^ pl[i];
    end
    exp.push_back(p);
    n = exp.size();
    got_par   = 8'h00;
    dest_addr = addr;
    start     = 1'b1;
    wr_en     = with_wr;
    wr_data   = 8'h99;
    tick();
    start   = 1'b0;
    wr_en   = 1'b0;
    got_hdr = data_out;
    k       = 0;
    cycles  = 0;
    while (k < n && cycles < 2000) begin
      check("tx_data", data_out, exp[k]);
      check("tx_pkt_valid", pkt_valid, k < n - 1);
      check("tx_active", tx_active, 1);
      check("tx_no_err", err, 0);
      if (k == n - 1) got_par = data_out;
      busy    = ((cycles < 32) ? mask[cycles] : 1'b0) | ($urandom_range(0, 99) < pct);
      start   = 1'($urandom_range(0, 1));
      wr_en   = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom);
      tick();
      cycles++;
      if (!busy) k++;
    end
    busy  = 1'b0;
    start = 1'b0;
    wr_en = 1'b0;
    check("tx_completed", k, n);
    check("done_pulse", done, 1);
    check("end_tx_active", tx_active, 0);
    check("end_pkt_valid", pkt_valid, 0);
    check("end_data_out", data_out, 0);
    check("end_load_full", load_full, 0);
    pl.delete();
    tick();
    check("done_one_cycle", done, 0);
  endtask

  vec_t       vecs[4];
  logic [7:0] gh, gp;
  int         cyc;
  int         len;
  logic [1:0] a;

  initial begin
    vecs[0] = '{3, 24'h112233, 2'd1, 8'h0D, 8'h0D};
    vecs[1] = '{1, 24'h010000, 2'd0, 8'h04, 8'h05};
    vecs[2] = '{2, 24'hAA5500, 2'd2, 8'h0A, 8'hF5};
    vecs[3] = '{1, 24'hFF0000, 2'd1, 8'h05, 8'hFA};

    reset_in = 1'b1; wr_en = 1'b0; wr_data = 8'h00; start = 1'b0;
    dest_addr = 2'd0; busy = 1'b0;
    #12;
    check("rst_data_out", data_out, 0);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_tx_active", tx_active, 0);
    check("rst_load_full", load_full, 0);
    check("rst_done_err", {done, err}, 0);
    @(negedge clk);
    reset_in = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < vecs[i].n; j++) wr_byte(vecs[i].bytes[23-8*j -: 8]);
      xmit(vecs[i].addr, 0, 32'h0, 1'b0, gh, gp, cyc);
      check("vec_header", gh, vecs[i].hdr);
      check("vec_parity", gp, vecs[i].par);
      check("vec_cycles", cyc, vecs[i].n + 2);
    end

    // stall while 8'h22 is presented
    wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
    xmit(2'd1, 0, 32'h0000_000C, 1'b0, gh, gp, cyc);
    check("stall_cycles", cyc, 7);
    check("stall_parity", gp, 8'h0D);

    // rejected starts
    dest_addr = 2'd1; start = 1'b1; tick(); start = 1'b0;
    check("err_empty", err, 1);
    check("err_empty_pv", pkt_valid, 0);
    check("err_empty_tx", tx_active, 0);
    tick();
    check("err_one_cycle", err, 0);
    wr_byte(8'h77);
    dest_addr = 2'd3; start = 1'b1; tick(); start = 1'b0;
    check("err_addr3", err, 1);
    check("err_addr3_tx", tx_active, 0);
    tick();
    xmit(2'd0, 0, 32'h0, 1'b0, gh, gp, cyc);
    check("after_err_hdr", gh, 8'h04);
    check("after_err_par", gp, 8'h73);

    // fill to capacity, the 64th write is dropped
    for (int i = 0; i < 64; i++) wr_byte(8'hA5);
    check("full_flag", load_full, 1);
    xmit(2'd2, 0, 32'h0, 1'b0, gh, gp, cyc);
    check("full_hdr", gh, 8'hFE);
    check("full_par", gp, 8'h5B);
    check("full_cycles", cyc, 65);

    // start with wr_en in the same cycle: byte not written
    wr_byte(8'h12); wr_byte(8'h34);
    xmit(2'd1, 0, 32'h0, 1'b1, gh, gp, cyc);
    check("start_wr_hdr", gh, 8'h09);
    check("start_wr_par", gp, 8'h2F);

    // asynchronous reset mid-payload
    for (int i = 0; i < 5; i++) wr_byte(8'(i + 1));
    dest_addr = 2'd2; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("pre_rst_pv", pkt_valid, 1);
    #2 reset_in = 1'b1;
    #1;
    check("async_rst_pv", pkt_valid, 0);
    check("async_rst_tx", tx_active, 0);
    check("async_rst_data", data_out, 0);
    pl.delete();
    @(negedge clk);
    reset_in = 1'b0;
    tick();
    check("post_rst_done", done, 0);
    wr_byte(8'h3C);
    xmit(2'd1, 0, 32'h0, 1'b0, gh, gp, cyc);
    check("post_rst_hdr", gh, 8'h05);
    check("post_rst_par", gp, 8'h39);

    // randomized packets with random stalls
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 20);
      a   = 2'($urandom_range(0, 2));
      for (int j = 0; j < len; j++) wr_byte(8'($urandom));
      xmit(a, 30, 32'h0, 1'($urandom_range(0, 1)), gh, gp, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
